// File: rtl/sdram_port_arb.sv
// -----------------------------------------------------------------------------
// sdram_port_arb
//   Three-client round-robin arbiter in front of a single toggle-handshake
//   SDRAM controller port. Each client issues a request by toggling cN_req;
//   the arbiter forwards one transfer at a time to the controller (mem_req
//   toggle / mem_ack toggle) and answers the client by toggling cN_ack, with
//   read data captured into a per-client cN_dout register.
//
//   A transfer that is not acknowledged within TIMEOUT cycles is aborted
//   towards the client (ack toggled, read data forced to all-ones, sticky
//   err raised). The arbiter then parks in HOLD until the controller's late
//   ack arrives, so the two toggle phases never get out of step.
//
// Ports
//   clk, reset                    : clock, synchronous active-high reset
//   cN_req / cN_ack   (N=0..2)    : client request / acknowledge toggles
//   cN_addr, cN_din, cN_we        : client word address, write data, write flag
//   cN_dout                       : per-client read data register
//   mem_req / mem_ack             : controller request / acknowledge toggles
//   mem_addr, mem_din, mem_we     : transfer fields, held stable between issues
//   mem_dout                      : controller read data
//   grant                         : client currently or last served
//   busy                          : arbiter not in IDLE
//   err                           : sticky timeout flag
// -----------------------------------------------------------------------------
module sdram_port_arb #(
    parameter logic [7:0] TIMEOUT = 8'd64
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        c0_req,
    output logic        c0_ack,
    input  logic [21:1] c0_addr,
    input  logic [15:0] c0_din,
    input  logic        c0_we,
    output logic [15:0] c0_dout,

    input  logic        c1_req,
    output logic        c1_ack,
    input  logic [21:1] c1_addr,
    input  logic [15:0] c1_din,
    input  logic        c1_we,
    output logic [15:0] c1_dout,

    input  logic        c2_req,
    output logic        c2_ack,
    input  logic [21:1] c2_addr,
    input  logic [15:0] c2_din,
    input  logic        c2_we,
    output logic [15:0] c2_dout,

    output logic        mem_req,
    input  logic        mem_ack,
    output logic [21:1] mem_addr,
    output logic [15:0] mem_din,
    output logic        mem_we,
    input  logic [15:0] mem_dout,

    output logic [1:0]  grant,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [7:0] TO_LAST = TIMEOUT - 8'd1;

    state_t      state_q;
    logic [2:0]  ack_q;
    logic [15:0] dout_q [3];
    logic        mem_req_q;
    logic [21:1] mem_addr_q;
    logic [15:0] mem_din_q;
    logic        mem_we_q;
    logic [1:0]  grant_q;
    logic        err_q;
    logic [7:0]  cnt_q;

    // A client is pending while its toggles differ; a second toggle while
    // already pending simply cancels the request.
    logic [2:0]  req_w;
    logic [2:0]  pending_w;

    assign req_w     = {c2_req, c1_req, c0_req};
    assign pending_w = req_w ^ ack_q;

    function automatic logic [1:0] next3(input logic [1:0] x);
        return (x >= 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    function automatic logic pend_at(input logic [2:0] p, input logic [1:0] idx);
        case (idx)
            2'd0:    return p[0];
            2'd1:    return p[1];
            default: return p[2];
        endcase
    endfunction

    // Round-robin: search starts one past the last grant and wraps.
    logic [1:0] cand0_w, cand1_w, cand2_w;
    logic       sel_valid_w;
    logic [1:0] sel_idx_w;

    assign cand0_w = next3(grant_q);
    assign cand1_w = next3(cand0_w);
    assign cand2_w = next3(cand1_w);

    always_comb begin
        sel_valid_w = 1'b0;
        sel_idx_w   = cand0_w;
        if (pend_at(pending_w, cand0_w)) begin
            sel_valid_w = 1'b1;
            sel_idx_w   = cand0_w;
        end else if (pend_at(pending_w, cand1_w)) begin
            sel_valid_w = 1'b1;
            sel_idx_w   = cand1_w;
        end else if (pend_at(pending_w, cand2_w)) begin
            sel_valid_w = 1'b1;
            sel_idx_w   = cand2_w;
        end
    end

    // Field mux for the selected client; only consulted on the issue edge.
    logic [21:1] sel_addr_w;
    logic [15:0] sel_din_w;
    logic        sel_we_w;

    always_comb begin
        case (sel_idx_w)
            2'd0: begin
                sel_addr_w = c0_addr;
                sel_din_w  = c0_din;
                sel_we_w   = c0_we;
            end
            2'd1: begin
                sel_addr_w = c1_addr;
                sel_din_w  = c1_din;
                sel_we_w   = c1_we;
            end
            default: begin
                sel_addr_w = c2_addr;
                sel_din_w  = c2_din;
                sel_we_w   = c2_we;
            end
        endcase
    end

    // The controller is idle only when its ack has caught up with our req;
    // this also keeps us quiet after a reset the controller did not see.
    logic mem_idle_w;
    assign mem_idle_w = (mem_ack == mem_req_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ack_q      <= 3'b000;
            for (int k = 0; k < 3; k++) dout_q[k] <= 16'h0000;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= 16'h0000;
            mem_we_q   <= 1'b0;
            grant_q    <= 2'd2;
            err_q      <= 1'b0;
            cnt_q      <= 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (sel_valid_w && mem_idle_w) begin
                        grant_q    <= sel_idx_w;
                        mem_addr_q <= sel_addr_w;
                        mem_din_q  <= sel_din_w;
                        mem_we_q   <= sel_we_w;
                        mem_req_q  <= ~mem_req_q;
                        cnt_q      <= 8'd0;
                        state_q    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_idle_w) begin
                        for (int k = 0; k < 3; k++) begin
                            if (grant_q == k[1:0]) begin
                                ack_q[k] <= ~ack_q[k];
                                if (!mem_we_q) dout_q[k] <= mem_dout;
                            end
                        end
                        state_q <= ST_IDLE;
                    end else if ((TIMEOUT != 8'd0) && (cnt_q == TO_LAST)) begin
                        // Release the client now; the controller's ack is
                        // still owed and is absorbed in HOLD.
                        for (int k = 0; k < 3; k++) begin
                            if (grant_q == k[1:0]) begin
                                ack_q[k] <= ~ack_q[k];
                                if (!mem_we_q) dout_q[k] <= 16'hFFFF;
                            end
                        end
                        err_q   <= 1'b1;
                        state_q <= ST_HOLD;
                    end else if (cnt_q != 8'hFF) begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_HOLD: begin
                    if (mem_idle_w) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign c0_ack   = ack_q[0];
    assign c1_ack   = ack_q[1];
    assign c2_ack   = ack_q[2];
    assign c0_dout  = dout_q[0];
    assign c1_dout  = dout_q[1];
    assign c2_dout  = dout_q[2];
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign mem_we   = mem_we_q;
    assign grant    = grant_q;
    assign busy     = (state_q != ST_IDLE);
    assign err      = err_q;

endmodule

// File: tb/tb_sdram_port_arb.sv
module tb_sdram_port_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic        c0_req, c1_req, c2_req;
    logic        c0_ack, c1_ack, c2_ack;
    logic [21:1] c0_addr, c1_addr, c2_addr;
    logic [15:0] c0_din, c1_din, c2_din;
    logic        c0_we, c1_we, c2_we;
    logic [15:0] c0_dout, c1_dout, c2_dout;
    logic        mem_req, mem_ack;
    logic [21:1] mem_addr;
    logic [15:0] mem_din, mem_dout;
    logic        mem_we;
    logic [1:0]  grant;
    logic        busy, err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sdram_port_arb #(.TIMEOUT(8'd8)) dut (
        .clk(clk), .reset(reset),
        .c0_req(c0_req), .c0_ack(c0_ack), .c0_addr(c0_addr), .c0_din(c0_din), .c0_we(c0_we), .c0_dout(c0_dout),
        .c1_req(c1_req), .c1_ack(c1_ack), .c1_addr(c1_addr), .c1_din(c1_din), .c1_we(c1_we), .c1_dout(c1_dout),
        .c2_req(c2_req), .c2_ack(c2_ack), .c2_addr(c2_addr), .c2_din(c2_din), .c2_we(c2_we), .c2_dout(c2_dout),
        .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_we(mem_we), .mem_dout(mem_dout),
        .grant(grant), .busy(busy), .err(err)
    );

    // All driving and sampling happens on the falling edge.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        c0_req = 0; c1_req = 0; c2_req = 0;
        c0_we = 0; c1_we = 0; c2_we = 0;
        c0_addr = '0; c1_addr = '0; c2_addr = '0;
        c0_din = '0; c1_din = '0; c2_din = '0;
        mem_ack = 1'b0; mem_dout = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
        checks++; if ({c2_ack, c1_ack, c0_ack} !== 3'b000) begin errors++; $display("FAIL reset_acks got %b exp 000", {c2_ack, c1_ack, c0_ack}); end
        checks++; if (grant !== 2'd2) begin errors++; $display("FAIL reset_grant got %0d exp 2", grant); end
        checks++; if ({busy, err, mem_we} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {busy, err, mem_we}); end
        checks++; if ({mem_addr, mem_din} !== 37'd0) begin errors++; $display("FAIL reset_mem_fields got %h exp 0", {mem_addr, mem_din}); end
        checks++; if ({c0_dout, c1_dout, c2_dout} !== 48'd0) begin errors++; $display("FAIL reset_douts got %h exp 0", {c0_dout, c1_dout, c2_dout}); end
        $display("reset: done");
    endtask

    task automatic test_single_read();
        do_reset();
        c0_addr = 21'h000100; c0_we = 1'b0; c0_req = 1'b1;
        @(negedge clk);
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL read_issue got %b exp 1", mem_req); end
        checks++; if (mem_addr !== 21'h000100) begin errors++; $display("FAIL read_addr got %h exp 000100", mem_addr); end
        checks++; if (grant !== 2'd0 || busy !== 1'b1) begin errors++; $display("FAIL read_grant got %0d/%b exp 0/1", grant, busy); end
        repeat (3) @(negedge clk);
        checks++; if (c0_ack !== 1'b0) begin errors++; $display("FAIL read_early_ack got %b exp 0", c0_ack); end
        mem_dout = 16'hA5A5; mem_ack = 1'b1;
        @(negedge clk);
        checks++; if (c0_ack !== 1'b1) begin errors++; $display("FAIL read_ack got %b exp 1", c0_ack); end
        checks++; if (c0_dout !== 16'hA5A5) begin errors++; $display("FAIL read_dout got %h exp a5a5", c0_dout); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read_idle got %b exp 0", busy); end
        $display("single_read: c0 addr=000100 dout=%h", c0_dout);
    endtask

    task automatic test_contention();
        logic [21:1] exp_addr [3];
        logic [15:0] exp_data [3];
        logic [2:0]  got_ack;
        logic        phase;
        exp_addr[0] = 21'h000010; exp_addr[1] = 21'h000020; exp_addr[2] = 21'h000030;
        do_reset();
        c0_addr = exp_addr[0]; c1_addr = exp_addr[1]; c2_addr = exp_addr[2];
        for (int r = 0; r < 2; r++) begin
            phase = (r == 0) ? 1'b1 : 1'b0;
            c0_req = phase; c1_req = phase; c2_req = phase;
            for (int i = 0; i < 3; i++) begin
                exp_data[i] = 16'h1000 + 16'(r * 16 + i);
                @(negedge clk);
                checks++; if (grant !== 2'(i)) begin errors++; $display("FAIL cont_grant r%0d got %0d exp %0d", r, grant, i); end
                checks++; if (mem_addr !== exp_addr[i]) begin errors++; $display("FAIL cont_addr r%0d got %h exp %h", r, mem_addr, exp_addr[i]); end
                checks++; if (mem_req === mem_ack) begin errors++; $display("FAIL cont_issue r%0d got req=%b ack=%b exp differ", r, mem_req, mem_ack); end
                @(negedge clk);
                mem_dout = exp_data[i]; mem_ack = mem_req;
                @(negedge clk);
                got_ack = {c2_ack, c1_ack, c0_ack};
                for (int j = 0; j < 3; j++) begin
                    checks++;
                    if (got_ack[j] !== ((j <= i) ? phase : ~phase)) begin
                        errors++; $display("FAIL cont_ack r%0d i%0d c%0d got %b exp %b", r, i, j, got_ack[j], (j <= i) ? phase : ~phase);
                    end
                end
                $display("contention: round %0d served c%0d", r, i);
            end
            checks++; if ({c0_dout, c1_dout, c2_dout} !== {exp_data[0], exp_data[1], exp_data[2]}) begin
                errors++; $display("FAIL cont_douts r%0d got %h exp %h", r, {c0_dout, c1_dout, c2_dout}, {exp_data[0], exp_data[1], exp_data[2]});
            end
        end
    endtask

    task automatic test_write();
        do_reset();
        c1_we = 1'b1; c1_din = 16'h1234; c1_addr = 21'h0ABCDE; c1_req = 1'b1;
        @(negedge clk);
        // Later changes to client inputs must not reach the held fields.
        c1_din = 16'hDEAD; c1_we = 1'b0; c1_addr = 21'h000000;
        checks++; if (mem_we !== 1'b1 || mem_din !== 16'h1234) begin errors++; $display("FAIL wr_issue got we=%b din=%h exp 1/1234", mem_we, mem_din); end
        repeat (2) @(negedge clk);
        checks++; if (mem_we !== 1'b1 || mem_din !== 16'h1234 || mem_addr !== 21'h0ABCDE) begin
            errors++; $display("FAIL wr_hold got we=%b din=%h addr=%h exp 1/1234/0abcde", mem_we, mem_din, mem_addr);
        end
        mem_dout = 16'h5555; mem_ack = mem_req;
        @(negedge clk);
        checks++; if (c1_ack !== 1'b1) begin errors++; $display("FAIL wr_ack got %b exp 1", c1_ack); end
        checks++; if (c1_dout !== 16'h0000) begin errors++; $display("FAIL wr_dout got %h exp 0000", c1_dout); end
        checks++; if (mem_din !== 16'h1234 || mem_we !== 1'b1) begin errors++; $display("FAIL wr_after got we=%b din=%h exp 1/1234", mem_we, mem_din); end
        $display("write: c1 din=1234 acked");
    endtask

    task automatic test_timeout();
        do_reset();
        c2_we = 1'b0; c2_addr = 21'h1FFFFF; c2_req = 1'b1;
        @(negedge clk);
        checks++; if (mem_req !== 1'b1 || grant !== 2'd2) begin errors++; $display("FAIL to_issue got req=%b grant=%0d exp 1/2", mem_req, grant); end
        repeat (7) @(negedge clk);
        checks++; if (c2_ack !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL to_early got ack=%b err=%b exp 0/0", c2_ack, err); end
        // Another client now waits; nothing may be issued while in HOLD.
        c0_req = 1'b1;
        @(negedge clk);
        checks++; if (c2_ack !== 1'b1) begin errors++; $display("FAIL to_ack got %b exp 1", c2_ack); end
        checks++; if (c2_dout !== 16'hFFFF) begin errors++; $display("FAIL to_dout got %h exp ffff", c2_dout); end
        checks++; if (err !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL to_hold got err=%b busy=%b exp 1/1", err, busy); end
        repeat (20) @(negedge clk);
        checks++; if (mem_req !== 1'b1 || busy !== 1'b1 || c0_ack !== 1'b0) begin
            errors++; $display("FAIL to_no_issue got req=%b busy=%b c0_ack=%b exp 1/1/0", mem_req, busy, c0_ack);
        end
        mem_dout = 16'h1111; mem_ack = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || c2_ack !== 1'b1 || c2_dout !== 16'hFFFF) begin
            errors++; $display("FAIL to_late_ack got busy=%b ack=%b dout=%h exp 0/1/ffff", busy, c2_ack, c2_dout);
        end
        @(negedge clk);
        checks++; if (mem_req !== 1'b0 || grant !== 2'd0 || err !== 1'b1) begin
            errors++; $display("FAIL to_resume got req=%b grant=%0d err=%b exp 0/0/1", mem_req, grant, err);
        end
        $display("timeout: c2 aborted, c0 issued after late ack");
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        c0_req = 1'b1; c0_addr = 21'h000042;
        @(negedge clk);
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rmw_issue got %b exp 1", mem_req); end
        @(negedge clk);
        // Controller acks while the arbiter is reset; the client drops too.
        reset = 1'b1; mem_ack = 1'b1; c0_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (c0_ack !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL rmw_after got ack=%b req=%b exp 0/0", c0_ack, mem_req); end
        c1_req = 1'b1; c1_addr = 21'h000077;
        repeat (4) @(negedge clk);
        checks++; if (mem_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rmw_blocked got req=%b busy=%b exp 0/0", mem_req, busy); end
        mem_ack = 1'b0;
        @(negedge clk);
        checks++; if (mem_req !== 1'b1 || grant !== 2'd1 || mem_addr !== 21'h000077) begin
            errors++; $display("FAIL rmw_issue_c1 got req=%b grant=%0d addr=%h exp 1/1/000077", mem_req, grant, mem_addr);
        end
        $display("reset_mid_wait: c1 issued after controller caught up");
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_single_read();
        test_contention();
        test_write();
        test_timeout();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sdram_port_arb.md
SDRAM_PORT_ARB -- requirements
Module: sdram_port_arb

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8'd64: cycles spent in WAIT before aborting; 0 disables the timeout.
REQ-002 SHALL have port clk, input, 1: single clock, the SDRAM controller clock.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have ports cN_req, input, 1, for N=0..2: client request toggle; pending while cN_req != cN_ack.
REQ-005 SHALL have ports cN_ack, output, 1, for N=0..2: client acknowledge toggle.
REQ-006 SHALL have ports cN_addr, input, 21 ([21:1]), for N=0..2: client word address.
REQ-007 SHALL have ports cN_din, input, 16, for N=0..2: client write data.
REQ-008 SHALL have ports cN_we, input, 1, for N=0..2: client write (1) or read (0).
REQ-009 SHALL have ports cN_dout, output, 16, for N=0..2: per-client read data register.
REQ-010 SHALL have port mem_req, output, 1: toggle request to the controller ROM port.
REQ-011 SHALL have port mem_ack, input, 1: toggle acknowledge from the controller.
REQ-012 SHALL have port mem_addr, output, 21: word address to the controller.
REQ-013 SHALL have port mem_din, output, 16: write data to the controller.
REQ-014 SHALL have port mem_we, output, 1: write strobe to the controller.
REQ-015 SHALL have port mem_dout, input, 16: read data from the controller.
REQ-016 SHALL have port grant, output, 2: index of the client currently or last served.
REQ-017 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-018 SHALL have port err, output, 1: sticky timeout flag.

Function
REQ-019 SHALL implement states IDLE, WAIT and HOLD.
REQ-020 In IDLE, when at least one client is pending and mem_ack == mem_req, SHALL select a client round-robin, searching from (grant+1) mod 3 upward with wrap-around.
REQ-021 On the selecting edge SHALL set grant, register mem_addr/mem_din/mem_we from that client, toggle mem_req, clear the timeout counter and enter WAIT; all of this happens one edge after the pending condition is sampled.
REQ-022 SHALL hold mem_addr, mem_din and mem_we stable from the issue edge until the next issue.
REQ-023 In WAIT, on the edge where mem_ack == mem_req: if the transfer was a read, cgrant_dout <= mem_dout; cgrant_ack <= cgrant_req; then enter IDLE.
REQ-024 cN_ack SHALL toggle for writes too, with cN_dout unchanged.
REQ-025 A new grant SHALL be possible on the edge after returning to IDLE, giving a minimum spacing of 2 cycles plus controller latency per transfer.
REQ-026 In WAIT, if TIMEOUT != 0 and the counter reaches TIMEOUT-1 without an ack, SHALL set err <= 1, toggle the granted cN_ack, and enter HOLD.
REQ-027 On a read timeout SHALL load cN_dout with 16'hFFFF.
REQ-028 HOLD SHALL issue nothing and return to IDLE on the edge where mem_ack == mem_req, with no timeout applied in HOLD.
REQ-029 A late ack arriving in HOLD SHALL NOT toggle any client ack and SHALL NOT update any dout.
REQ-030 The timeout counter SHALL be 8 bits, SHALL saturate, and SHALL count only in WAIT.
REQ-031 A client toggling cN_req again while already pending is illegal; SHALL treat it as "not pending" (req == ack) with no other effect.
REQ-032 Inputs of non-granted clients SHALL be ignored.
REQ-033 A client's inputs SHALL be sampled only on its issue edge.
REQ-034 When two or more clients become pending on the same cycle, only round-robin order SHALL decide which is served.
REQ-035 err SHALL be cleared only by reset.

Reset
REQ-036 On reset: state IDLE, mem_req 0, mem_addr 0, mem_din 0, mem_we 0, all cN_ack 0, all cN_dout 0, grant 2'd2 (so client 0 is searched first), busy 0, err 0, counter 0.
REQ-037 Reset asserted mid-WAIT SHALL abandon the transfer without acking the client.
REQ-038 After reset, while mem_ack != mem_req (controller not reset), SHALL issue nothing until they match.

Verification
REQ-039 Single read: c0 toggles req with addr 21'h000100; controller acks 4 cycles later with 16'hA5A5 -> mem_req toggles 1 edge after c0_req, c0_dout == 16'hA5A5, c0_ack == c0_req one edge after mem_ack matches.
REQ-040 Contention: c0, c1, c2 toggle on the same cycle from reset -> grants served in order 0, 1, 2; next simultaneous round, with grant=2, again serves 0, 1, 2; every ack toggles exactly once.
REQ-041 Write: c1_we=1, c1_din=16'h1234 -> mem_we=1 and mem_din=16'h1234 held until ack; c1_dout stays 0; c1_ack toggles.
REQ-042 Timeout: TIMEOUT=8, controller never acks -> c2_ack toggles 8 cycles after issue, c2_dout=16'hFFFF, err=1, state HOLD; no new issue until mem_ack is forced to match, then IDLE.
REQ-043 Reset mid-WAIT with mem_ack lagging -> c0_ack=0 and mem_req=0 after reset; a pending c1 request is not issued while mem_ack=1, and is issued on the edge after mem_ack returns to 0.
